// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, dump FSM states and the XZR/bypass read rule
package regfile_pkg;
  localparam int N = 64;
  localparam int REG_CNT = 32;
  localparam logic [4:0] XZR_IDX = 5'd31;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} dump_state_t;
  typedef logic [REG_CNT-1:0][N-1:0] reg_arr_t;
  function automatic logic [N-1:0] reg_read(
    input reg_arr_t       arr,
    input logic [4:0]     addr,
    input logic           we,
    input logic [4:0]     wa,
    input logic [N-1:0]   wd
  );
    return (addr == XZR_IDX) ? '0 : (we && wa == addr) ? wd : arr[addr];
  endfunction
endpackage

// File: rtl/regfile_dump_fsm.sv
// regfile_dump_fsm: dump sequencer producing the register index and valid/done strobes
module regfile_dump_fsm
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dump_start,
  input  logic       dump_ready,
  output logic       dump_valid,
  output logic       dump_done,
  output logic [4:0] dump_idx
);
  dump_state_t r_state;
  logic        r_valid;
  logic        r_done;
  logic [4:0]  r_idx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (dump_start) begin
          r_state <= STREAM;
          r_valid <= 1'b1;
          r_idx   <= '0;
        end
        STREAM: if (dump_ready) begin
          if (r_idx == XZR_IDX) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else r_idx <= r_idx + 5'd1;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  assign dump_valid = r_valid;
  assign dump_done  = r_done;
  assign dump_idx   = r_idx;
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: LEGv8 register file with XZR, write-through reads and a valid/ready state dump
module regfile_dump
  import regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2,
  input  logic         we3,
  input  logic [4:0]   wa3,
  input  logic [N-1:0] wd3,
  input  logic         dump_start,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [4:0]   dump_idx,
  output logic [N-1:0] dump_data,
  output logic         dump_done
);
  reg_arr_t   r_x;
  logic [4:0] w_idx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < REG_CNT; i++) r_x[i] <= N'(i);
    else if (we3 && wa3 != XZR_IDX) r_x[wa3] <= wd3;
  assign rd1       = reg_read(r_x, ra1, we3, wa3, wd3);
  assign rd2       = reg_read(r_x, ra2, we3, wa3, wd3);
  assign dump_data = reg_read(r_x, w_idx, we3, wa3, wd3);
  assign dump_idx  = w_idx;
  regfile_dump_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_idx   (w_idx)
  );
endmodule
